// File: rtl/muldiv_unit.sv
// Multi-cycle multiply / divide / multiply-accumulate unit with a full {HI,LO} result.
// Optional build macro MULDIV_DIV_EARLY_OUT_EN: single-cycle divide for b == 0 or |a| < |b|.
module muldiv_unit #(
    parameter int WIDTH       = 32,
    parameter int MUL_LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2*WIDTH-1:0]   hilo_in,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   hilo_out,
    output logic                 busy,
    output logic [1:0]           dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int CNT_W = $clog2(WIDTH + MUL_LATENCY + 1);
    localparam logic [CNT_W-1:0] DIV_CNT_INIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] MUL_CNT_INIT = CNT_W'((MUL_LATENCY >= 2) ? (MUL_LATENCY - 2) : 0);

    logic [1:0]           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [2:0]           r_op;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [2*WIDTH-1:0]   r_hilo_in;
    logic [WIDTH-1:0]     r_dvd_q;
    logic [WIDTH-1:0]     r_mag_b;
    logic [WIDTH-1:0]     r_rem;
    logic [2*WIDTH-1:0]   r_hilo_out;

    // Handshake: a request moves on an edge where in_valid & in_ready & ~flush;
    // a result moves on an edge where out_valid & out_ready.
    assign in_ready  = (r_state == S_IDLE) && !reset;
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign hilo_out  = r_hilo_out;
    assign dbg_state = r_state;

    // Decode of the incoming request.
    logic                 w_in_signed;
    logic                 w_in_is_div;
    logic [WIDTH-1:0]     w_in_mag_a;
    logic [WIDTH-1:0]     w_in_mag_b;

    assign w_in_signed = ~op[0];
    assign w_in_is_div = (op[2:1] == 2'b01);
    assign w_in_mag_a  = (w_in_signed && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign w_in_mag_b  = (w_in_signed && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // Multiply path. With a latency of one the result is formed straight from the
    // ports at acceptance; otherwise from the registered operands on the last MUL cycle.
    logic [2:0]           w_m_op;
    logic [WIDTH-1:0]     w_m_ma;
    logic [WIDTH-1:0]     w_m_mb;
    logic [2*WIDTH-1:0]   w_m_hilo;
    logic                 w_m_neg;
    logic [2*WIDTH-1:0]   w_prod_mag;
    logic [2*WIDTH-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_mul_res;

    always_comb begin
        if (MUL_LATENCY == 1) begin
            w_m_op   = op;
            w_m_ma   = w_in_mag_a;
            w_m_mb   = w_in_mag_b;
            w_m_hilo = hilo_in;
            w_m_neg  = ~op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
        end else begin
            w_m_op   = r_op;
            w_m_ma   = r_dvd_q;
            w_m_mb   = r_mag_b;
            w_m_hilo = r_hilo_in;
            w_m_neg  = ~r_op[0] & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
        end
    end

    assign w_prod_mag = (2*WIDTH)'(w_m_ma) * (2*WIDTH)'(w_m_mb);
    assign w_prod     = w_m_neg ? (~w_prod_mag + 1'b1) : w_prod_mag;

    always_comb begin
        w_mul_res = w_prod;
        if (w_m_op[2]) begin
            if (w_m_op[1]) begin
                w_mul_res = w_m_hilo - w_prod;
            end else begin
                w_mul_res = w_m_hilo + w_prod;
            end
        end
    end

    // Restoring divide step: r_dvd_q shifts dividend bits out of the top while
    // quotient bits shift in at the bottom.
    logic [WIDTH:0]       w_div_shift;
    logic                 w_div_ge;
    logic [WIDTH-1:0]     w_div_sub;
    logic [WIDTH-1:0]     w_rem_next;
    logic [WIDTH-1:0]     w_quot_next;
    logic                 w_q_neg;
    logic                 w_r_neg;
    logic [WIDTH-1:0]     w_quot_fix;
    logic [WIDTH-1:0]     w_rem_fix;
    logic [2*WIDTH-1:0]   w_div_res;

    assign w_div_shift = {r_rem, r_dvd_q[WIDTH-1]};
    assign w_div_ge    = (w_div_shift >= {1'b0, r_mag_b});
    assign w_div_sub   = w_div_shift[WIDTH-1:0] - r_mag_b;
    assign w_rem_next  = w_div_ge ? w_div_sub : w_div_shift[WIDTH-1:0];
    assign w_quot_next = {r_dvd_q[WIDTH-2:0], w_div_ge};

    assign w_q_neg    = ~r_op[0] & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
    assign w_r_neg    = ~r_op[0] & r_a[WIDTH-1];
    assign w_quot_fix = w_q_neg ? (~w_quot_next + 1'b1) : w_quot_next;
    assign w_rem_fix  = w_r_neg ? (~w_rem_next + 1'b1) : w_rem_next;
    assign w_div_res  = (r_b == '0) ? {r_a, {WIDTH{1'b1}}} : {w_rem_fix, w_quot_fix};

`ifdef MULDIV_DIV_EARLY_OUT_EN
    logic                 w_early;
    logic [2*WIDTH-1:0]   w_early_res;

    // Both shortcuts leave HI = a untouched; only LO differs.
    assign w_early     = (b == '0) || (w_in_mag_a < w_in_mag_b);
    assign w_early_res = {a, (b == '0) ? {WIDTH{1'b1}} : {WIDTH{1'b0}}};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_hilo_in  <= '0;
            r_dvd_q    <= '0;
            r_mag_b    <= '0;
            r_rem      <= '0;
            r_hilo_out <= '0;
        end else if (flush) begin
            r_state    <= S_IDLE;
            r_hilo_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_op      <= op;
                        r_a       <= a;
                        r_b       <= b;
                        r_hilo_in <= hilo_in;
                        r_dvd_q   <= w_in_mag_a;
                        r_mag_b   <= w_in_mag_b;
                        r_rem     <= '0;
                        if (w_in_is_div) begin
`ifdef MULDIV_DIV_EARLY_OUT_EN
                            if (w_early) begin
                                r_state    <= S_DONE;
                                r_hilo_out <= w_early_res;
                            end else
`endif
                            begin
                                r_state <= S_DIV;
                                r_cnt   <= DIV_CNT_INIT;
                            end
                        end else if (MUL_LATENCY == 1) begin
                            r_state    <= S_DONE;
                            r_hilo_out <= w_mul_res;
                        end else begin
                            r_state <= S_MUL;
                            r_cnt   <= MUL_CNT_INIT;
                        end
                    end
                end
                S_MUL: begin
                    if (r_cnt == '0) begin
                        r_state    <= S_DONE;
                        r_hilo_out <= w_mul_res;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DIV: begin
                    r_dvd_q <= w_quot_next;
                    r_rem   <= w_rem_next;
                    // Last quotient bit and sign fix-up land on the same edge.
                    if (r_cnt == '0) begin
                        r_state    <= S_DONE;
                        r_hilo_out <= w_div_res;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    if (out_ready) begin
                        r_state    <= S_IDLE;
                        r_hilo_out <= '0;
                    end
                end
            endcase
        end
    end

endmodule
